fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of imem. It owns the program counter and drives imem's word address combinationally. It captures the returned 16-bit instruction into an IF/ID holding register with a valid/ready handshake to decode. It handles stalls, branch/jump redirects (flush) and a halt instruction.

Parameters:
- ADDR_W, 5, PC / imem word-address width
- INSTR_W, 16, instruction width
- RESET_PC, 5'h00, PC value loaded on reset
- HALT_OPCODE, 4'hF, instr[15:12] value that marks a halt instruction

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- imem_addr  output  ADDR_W  address to imem (= pc, combinational)
- imem_instr  input  INSTR_W  instruction returned by imem (combinational read)
- redirect_valid  input  1  taken branch/jump from a later stage
- redirect_target  input  ADDR_W  new PC when redirect_valid
- id_ready  input  1  decode accepts if_instr this cycle
- if_valid  output  1  IF/ID register holds a valid instruction
- if_instr  output  INSTR_W  latched instruction
- if_pc  output  ADDR_W  PC of latched instruction
- if_pc_plus1  output  ADDR_W  if_pc + 1, mod 2^ADDR_W
- halted  output  1  high while FSM is in S_HALT

Behaviour:
- One clock domain; reset is synchronous and active-high: clk and reset as named above.
- Reset values: pc=RESET_PC, if_valid=0, if_instr=16'h0000 (NOP), if_pc=0, halted=0, state=S_RUN.
- imem_addr = pc at all times, with zero-latency combinational read. The instruction is captured on the same edge that advances pc.
- Define fire = !if_valid || id_ready. The register is free or is being consumed.
- Priority per edge: reset > redirect_valid > stall (!fire) > halt hold > normal fetch.
- Redirect, in any state: pc<=redirect_target, if_valid<=0 (flush the younger instruction), state<=S_RUN. This cancels a speculatively fetched halt.
- Stall (!fire, no redirect): pc, if_valid, if_instr, if_pc all hold.
- S_RUN with fire: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+1.
  - If imem_instr[15:12]==HALT_OPCODE, state<=S_HALT and pc holds instead of incrementing.
- S_HALT: pc frozen and no new fetches. If id_ready && if_valid then if_valid<=0 (the halt drains); otherwise hold. Exit only via redirect or reset.
- PC arithmetic: ADDR_W bits, 5'h1F+1 wraps to 5'h00 silently.
- Redirect and id_ready both high: redirect wins and the current IF/ID contents are dropped, not delivered.
- Reset mid-stall or in S_HALT: all state returns to reset values next edge.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports fetch_count[15:0] and stall_count[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - fetch_count increments on every S_RUN fire capture.
  - stall_count increments every cycle if_valid && !id_ready && !redirect_valid.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W and INSTR_W defaults
  - NOP_INSTR (16'h0000)
  - HALT_OPCODE default
  - typedef enum logic {S_RUN, S_HALT} fetch_state_t
  - typedef logic [ADDR_W-1:0] pc_t
- One sub-module, pc_reg: the PC register with synchronous reset to RESET_PC, a load port (redirect) and an increment enable. Priority inside it is reset > load > inc.

Test Plan:
- Reset then id_ready=1, imem holding 16'h1001..16'h1005 at 0..4 -> imem_addr 0,1,2,3,4 on consecutive cycles; if_instr follows one cycle later; if_pc_plus1=if_pc+1.
- Stall: id_ready=0 for 3 cycles at pc=3 -> pc, if_instr, if_pc frozen at 3/instr[2]/2; resume on id_ready=1 with no instruction lost or duplicated.
- Redirect to 5'h10 while if_valid=1, id_ready=1 -> next cycle if_valid=0, imem_addr=5'h10; the following cycle if_instr=mem[16], if_pc=5'h10.
- Halt: mem[2]=16'hF000 -> halted=1 after capture, imem_addr stuck at 2, if_valid drops after one id_ready; redirect_valid with target 5'h08 -> halted=0, fetch resumes at 8.
- Wrap: redirect to 5'h1F, run 2 cycles -> if_pc 5'h1F then 5'h00.
- Reset asserted during a stall in S_HALT -> next edge: pc=0, if_valid=0, halted=0. With FETCH_PERF_EN defined, fetch_count and stall_count also read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and types for the fetch stage
package fetch_pkg;
   localparam int ADDR_W = 5;
   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
   localparam logic [3:0] HALT_OPCODE = 4'hF;

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} fetch_state_t;
   typedef logic [ADDR_W-1:0] pc_t;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - program counter register with load and increment
// Priority reset > load > inc; increment wraps modulo 2^ADDR_W.
module pc_reg
   import fetch_pkg::*;
#(
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else if (load)
         pc <= load_value;
      else if (inc)
         pc <= pc + 1'b1;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, redirect and halt
// Optional FETCH_PERF_EN adds saturating fetch_count and stall_count outputs.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_plus1,
   output logic               halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        fetch_count,
   output logic [15:0]        stall_count
`endif
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic              fire;
   logic              is_halt;
   logic              capture;
   logic              pc_inc;

   assign fire      = !if_valid || id_ready;
   assign is_halt   = (imem_instr[INSTR_W-1:INSTR_W-4] == HALT_OPCODE);
   assign capture   = !redirect_valid && fire && (state == S_RUN);
   // A fetched halt keeps pc pointing at itself so nothing past it is fetched.
   assign pc_inc    = capture && !is_halt;
   assign imem_addr = pc;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (redirect_valid),
      .load_value (redirect_target),
      .inc        (pc_inc),
      .pc         (pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RUN;
         if_valid <= 1'b0;
         if_instr <= INSTR_W'(NOP_INSTR);
         if_pc    <= '0;
      end else if (redirect_valid) begin
         state    <= S_RUN;
         if_valid <= 1'b0;
      end else if (!fire) begin
         state    <= state;
      end else if (state == S_HALT) begin
         if (id_ready && if_valid)
            if_valid <= 1'b0;
      end else begin
         if_instr <= imem_instr;
         if_pc    <= pc;
         if_valid <= 1'b1;
         if (is_halt)
            state <= S_HALT;
      end
   end

   assign if_pc_plus1 = if_pc + 1'b1;
   assign halted      = (state == S_HALT);

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (capture && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
         if (if_valid && !id_ready && !redirect_valid && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  imem_addr;
   logic [15:0] imem_instr;
   logic        redirect_valid;
   logic [4:0]  redirect_target;
   logic        id_ready;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [4:0]  if_pc;
   logic [4:0]  if_pc_plus1;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count;
   logic [15:0] stall_count;
`endif

   logic [15:0] mem [32];
   int checks;
   int errors;

   assign imem_instr = mem[imem_addr];

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_ready        (id_ready),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_plus1     (if_pc_plus1),
      .halted          (halted)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [4:0] target);
      redirect_valid  = 1'b1;
      redirect_target = target;
      step();
      redirect_valid  = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) mem[i] = 16'h2000 + 16'(i);
      for (int i = 0; i < 5; i++) mem[i] = 16'h1001 + 16'(i);
      reset = 1'b1;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 5'h00;
      step();
      step();
      reset = 1'b0;

      check("rst_addr", 32'(imem_addr), 32'h0);
      check("rst_valid", 32'(if_valid), 32'h0);
      check("rst_instr", 32'(if_instr), 32'h0);
      check("rst_pc", 32'(if_pc), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
`ifdef FETCH_PERF_EN
      check("rst_fetch_cnt", 32'(fetch_count), 32'h0);
      check("rst_stall_cnt", 32'(stall_count), 32'h0);
`endif

      // Sequential fetch 0..4
      id_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("seq_addr", 32'(imem_addr), 32'(k));
         step();
         check("seq_valid", 32'(if_valid), 32'h1);
         check("seq_instr", 32'(if_instr), 32'h1001 + 32'(k));
         check("seq_pc", 32'(if_pc), 32'(k));
         check("seq_pc1", 32'(if_pc_plus1), 32'(k + 1));
      end

      // Stall with pc=3 holding instr from address 2
      redirect_to(5'h02);
      check("rd2_valid", 32'(if_valid), 32'h0);
      step();
      check("st_pre_instr", 32'(if_instr), 32'h1003);
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("st_addr", 32'(imem_addr), 32'h3);
         check("st_instr", 32'(if_instr), 32'h1003);
         check("st_pc", 32'(if_pc), 32'h2);
         check("st_valid", 32'(if_valid), 32'h1);
      end
      id_ready = 1'b1;
      step();
      check("st_res_instr", 32'(if_instr), 32'h1004);
      check("st_res_pc", 32'(if_pc), 32'h3);
      step();
      check("st_res2_instr", 32'(if_instr), 32'h1005);
      check("st_res2_pc", 32'(if_pc), 32'h4);

      // Redirect with id_ready high drops the current contents
      redirect_to(5'h10);
      check("rd_valid", 32'(if_valid), 32'h0);
      check("rd_addr", 32'(imem_addr), 32'h10);
      step();
      check("rd_instr", 32'(if_instr), 32'h2010);
      check("rd_pc", 32'(if_pc), 32'h10);
      check("rd_valid2", 32'(if_valid), 32'h1);

      // Halt at address 2
      mem[2] = 16'hF000;
      redirect_to(5'h00);
      step();
      step();
      step();
      check("h_halted", 32'(halted), 32'h1);
      check("h_addr", 32'(imem_addr), 32'h2);
      check("h_instr", 32'(if_instr), 32'hF000);
      check("h_valid", 32'(if_valid), 32'h1);
      step();
      check("h_drain_valid", 32'(if_valid), 32'h0);
      check("h_drain_halted", 32'(halted), 32'h1);
      step();
      check("h_hold_addr", 32'(imem_addr), 32'h2);
      check("h_hold_valid", 32'(if_valid), 32'h0);
      redirect_to(5'h08);
      check("h_exit_halted", 32'(halted), 32'h0);
      check("h_exit_addr", 32'(imem_addr), 32'h8);
      step();
      check("h_exit_instr", 32'(if_instr), 32'h2008);
      check("h_exit_pc", 32'(if_pc), 32'h8);

      // PC wrap
      redirect_to(5'h1F);
      step();
      check("w_pc", 32'(if_pc), 32'h1F);
      check("w_pc1", 32'(if_pc_plus1), 32'h0);
      check("w_instr", 32'(if_instr), 32'h201F);
      step();
      check("w2_pc", 32'(if_pc), 32'h0);
      check("w2_instr", 32'(if_instr), 32'h1001);

      // Reset during stall in halt
      redirect_to(5'h00);
      step();
      step();
      step();
      id_ready = 1'b0;
      step();
      check("rh_halted_pre", 32'(halted), 32'h1);
      check("rh_valid_pre", 32'(if_valid), 32'h1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rh_addr", 32'(imem_addr), 32'h0);
      check("rh_valid", 32'(if_valid), 32'h0);
      check("rh_halted", 32'(halted), 32'h0);
      check("rh_instr", 32'(if_instr), 32'h0);
      check("rh_pc", 32'(if_pc), 32'h0);
`ifdef FETCH_PERF_EN
      check("rh_fetch_cnt", 32'(fetch_count), 32'h0);
      check("rh_stall_cnt", 32'(stall_count), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
